bounce_generator: RTL and testbench



---
 rtl/bounce_generator.sv | 116 +++++++++++
 tb/tb_bounce_generator.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/bounce_generator.sv
// Contact-bounce emulator: LFSR-timed chatter on bouncing_o for BOUNCE_CYCLES clocks after each qualifying level_i edge.
// Define BOUNCE_GEN_RELEASE_BOUNCE_EN to also bounce on release; otherwise a release drops the output on the same edge.
module bounce_generator #(
  parameter int unsigned BOUNCE_CYCLES = 400,
  parameter int unsigned MIN_PULSE     = 4,
  parameter int unsigned MAX_PULSE     = 32,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic level_i,
  output logic bouncing_o,
  output logic busy_o
);

  typedef enum logic {
    STABLE = 1'b0,
    BOUNCE = 1'b1
  } state_t;

  localparam logic [23:0] WIN_LAST  = 24'(BOUNCE_CYCLES - 1);
  localparam logic [15:0] SEG_MIN   = 16'(MIN_PULSE);
  localparam logic [15:0] SEG_MASK  = 16'(MAX_PULSE - 1);
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  state_t      state_q, state_d;
  logic        target_q, target_d;
  logic        bouncing_q, bouncing_d;
  logic [23:0] win_q, win_d;
  logic [15:0] seg_q, seg_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [15:0] seg_len;
  logic        level_edge;
  logic        bounce_edge;
  logic        drop_edge;

  assign level_edge = (level_i != target_q);

`ifdef BOUNCE_GEN_RELEASE_BOUNCE_EN
  assign bounce_edge = level_edge;
  assign drop_edge   = 1'b0;
`else
  assign bounce_edge = level_edge & level_i;
  assign drop_edge   = level_edge & ~level_i;
`endif

  assign seg_len = SEG_MIN + (lfsr_q & SEG_MASK);

  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    bouncing_d = bouncing_q;
    win_d      = win_q;
    seg_d      = seg_q;
    lfsr_d     = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_TAPS) : (lfsr_q >> 1);

    case (state_q)
      STABLE: begin
        if (bounce_edge) begin
          target_d   = level_i;
          bouncing_d = level_i;
          win_d      = '0;
          seg_d      = seg_len;
          state_d    = BOUNCE;
        end else if (drop_edge) begin
          target_d   = 1'b0;
          bouncing_d = 1'b0;
        end
      end
      BOUNCE: begin
        win_d = win_q + 24'd1;
        if (bounce_edge) begin
          // A new edge inside the window restarts it from scratch.
          target_d   = level_i;
          bouncing_d = level_i;
          win_d      = '0;
          seg_d      = seg_len;
        end else if (drop_edge) begin
          target_d   = 1'b0;
          bouncing_d = 1'b0;
          state_d    = STABLE;
        end else if (win_q == WIN_LAST) begin
          bouncing_d = target_q;
          state_d    = STABLE;
        end else if (seg_q == 16'd1) begin
          bouncing_d = ~bouncing_q;
          seg_d      = seg_len;
        end else begin
          seg_d = seg_q - 16'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= STABLE;
      target_q   <= 1'b0;
      bouncing_q <= 1'b0;
      win_q      <= '0;
      seg_q      <= '0;
      lfsr_q     <= LFSR_SEED;
    end else begin
      state_q    <= state_d;
      target_q   <= target_d;
      bouncing_q <= bouncing_d;
      win_q      <= win_d;
      seg_q      <= seg_d;
      lfsr_q     <= lfsr_d;
    end
  end

  assign bouncing_o = bouncing_q;
  assign busy_o     = (state_q == BOUNCE);

endmodule

// File: tb/tb_bounce_generator.sv
// Directed bench for bounce_generator (BOUNCE_CYCLES=20, MIN_PULSE=2, MAX_PULSE=4, default seed).
// Press pattern below is hand-derived from the LFSR sequence starting at 16'hACE1.
module tb_bounce_generator;

  logic clk_i;
  logic reset_i;
  logic level_i;
  logic bouncing_o;
  logic busy_o;

  int n_checks = 0;
  int n_fails  = 0;

  // bouncing_o after edge k+j for j=0..20 when pressing on the 11th clock after reset.
  logic [20:0] press_pat;

  bounce_generator #(
    .BOUNCE_CYCLES(20),
    .MIN_PULSE    (2),
    .MAX_PULSE    (4),
    .LFSR_SEED    (16'hACE1)
  ) dut (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .level_i   (level_i),
    .bouncing_o(bouncing_o),
    .busy_o    (busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Two reset clocks, then ten idle clocks, leaving the LFSR ready for a press on the next edge.
  task automatic restart();
    reset_i = 1'b1;
    level_i = 1'b0;
    step();
    step();
    reset_i = 1'b0;
    repeat (10) step();
  endtask

  // Presses on the next edge and checks positions j=0..n_j-1; ends positioned at j=n_j-1.
  task automatic press_check(input string tag, input int n_j);
    level_i = 1'b1;
    step();
    for (int j = 0; j < n_j; j++) begin
      chk($sformatf("%s_bounce_j%0d", tag, j), {31'd0, bouncing_o},
          {31'd0, (j <= 20) ? press_pat[j] : 1'b1});
      chk($sformatf("%s_busy_j%0d", tag, j), {31'd0, busy_o}, {31'd0, (j < 20)});
      if (j < n_j - 1) step();
    end
  endtask

  initial begin
    press_pat = 21'b1_0111_1100_0011_1000_0111;
    reset_i   = 1'b1;
    level_i   = 1'b0;

    // Reset and idle
    repeat (3) step();
    chk("rst_bounce", {31'd0, bouncing_o}, 32'd0);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    reset_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("idle_bounce_%0d", i), {31'd0, bouncing_o}, 32'd0);
      chk($sformatf("idle_busy_%0d", i), {31'd0, busy_o}, 32'd0);
    end

    // Press: full window plus settled tail
    press_check("press", 50);

    // Reset mid-window, then a repeated press reproduces the same chatter
    restart();
    press_check("pre_rst", 5);
    reset_i = 1'b1;
    level_i = 1'b0;
    step();
    chk("midrst_bounce", {31'd0, bouncing_o}, 32'd0);
    chk("midrst_busy", {31'd0, busy_o}, 32'd0);
    step();
    reset_i = 1'b0;
    repeat (10) step();
    press_check("repeat", 26);

`ifndef BOUNCE_GEN_RELEASE_BOUNCE_EN
    // Release from STABLE drops immediately without bouncing
    level_i = 1'b0;
    step();
    chk("rel_stable_bounce", {31'd0, bouncing_o}, 32'd0);
    chk("rel_stable_busy", {31'd0, busy_o}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("rel_quiet_bounce_%0d", i), {31'd0, bouncing_o}, 32'd0);
      chk($sformatf("rel_quiet_busy_%0d", i), {31'd0, busy_o}, 32'd0);
    end
`endif

    // Release at k+7, inside the press window
    restart();
    press_check("rev", 7);
    level_i = 1'b0;
    step();
`ifdef BOUNCE_GEN_RELEASE_BOUNCE_EN
    for (int j = 7; j < 37; j++) begin
      if (j == 7 || j >= 27)
        chk($sformatf("rev_bounce_j%0d", j), {31'd0, bouncing_o}, 32'd0);
      chk($sformatf("rev_busy_j%0d", j), {31'd0, busy_o}, {31'd0, (j < 27)});
      step();
    end
`else
    chk("abort_bounce", {31'd0, bouncing_o}, 32'd0);
    chk("abort_busy", {31'd0, busy_o}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("abort_quiet_bounce_%0d", i), {31'd0, bouncing_o}, 32'd0);
      chk($sformatf("abort_quiet_busy_%0d", i), {31'd0, busy_o}, 32'd0);
    end
`endif

    // Level toggling every cycle keeps restarting (or aborting) the window
    for (int i = 0; i < 20; i++) begin
      level_i = ~level_i;
      step();
      chk($sformatf("tgl_bounce_%0d", i), {31'd0, bouncing_o}, {31'd0, level_i});
`ifdef BOUNCE_GEN_RELEASE_BOUNCE_EN
      chk($sformatf("tgl_busy_%0d", i), {31'd0, busy_o}, 32'd1);
`else
      chk($sformatf("tgl_busy_%0d", i), {31'd0, busy_o}, {31'd0, level_i});
`endif
    end

    // Level already high when reset releases is a press on the first clock
    reset_i = 1'b1;
    level_i = 1'b1;
    step();
    step();
    chk("rst_hi_bounce", {31'd0, bouncing_o}, 32'd0);
    chk("rst_hi_busy", {31'd0, busy_o}, 32'd0);
    reset_i = 1'b0;
    step();
    chk("out_of_rst_bounce", {31'd0, bouncing_o}, 32'd1);
    chk("out_of_rst_busy", {31'd0, busy_o}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
